// File: rtl/sid_pkg.sv
// Shared definitions for the SID voice oscillator: register map, CONTROL
// bit layout and noise LFSR constants.
package sid_pkg;

  // Voice register addresses
  localparam logic [2:0] SID_FREQ_LO = 3'd0;
  localparam logic [2:0] SID_FREQ_HI = 3'd1;
  localparam logic [2:0] SID_PW_LO   = 3'd2;
  localparam logic [2:0] SID_PW_HI   = 3'd3;
  localparam logic [2:0] SID_CONTROL = 3'd4;
  localparam logic [2:0] SID_AD      = 3'd5;
  localparam logic [2:0] SID_SR      = 3'd6;

  // CONTROL register; packed MSB-first so gate lands on bit 0
  typedef struct packed {
    logic noise;
    logic pulse;
    logic saw;
    logic triangle;
    logic test;
    logic ring;
    logic sync_en;
    logic gate;
  } sid_ctrl_t;

  // Noise generator constants
  localparam int              SID_LFSR_W        = 23;
  localparam logic [22:0]     LFSR_SEED_DEFAULT = 23'h7FFFF8;
  localparam int              LFSR_TAP_HI       = 22;
  localparam int              LFSR_TAP_LO       = 17;

endpackage

// File: rtl/sid_noise_lfsr.sv
// Noise shift register for one SID voice. load (reseed) wins over shift.
import sid_pkg::*;

module sid_noise_lfsr #(
  parameter int              LFSR_W    = SID_LFSR_W,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift,
  input  logic              load,
  output logic [LFSR_W-1:0] lfsr
);

  logic feedback;

  // Feedback bit from the two taps
  always_comb begin
    feedback = lfsr[LFSR_TAP_HI] ^ lfsr[LFSR_TAP_LO];
  end

  // Shift register: reseed, shift left with feedback into bit 0, or hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else if (load) begin
      lfsr <= LFSR_SEED;
    end else if (shift) begin
      lfsr <= {lfsr[LFSR_W-2:0], feedback};
    end
  end

endmodule

// File: rtl/sid_voice_osc.sv
// SID voice oscillator: per-voice register bank, 24-bit phase accumulator
// and noise LFSR, advancing on the 1 MHz tick enable.
// Optional macro SID_TEST_LFSR_RESET_EN: when defined, the test bit reseeds
// the LFSR on every tick instead of just freezing it.
import sid_pkg::*;

module sid_voice_osc #(
  parameter int                ACC_W     = 24,
  parameter int                LFSR_W    = 23,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFF8,
  parameter int                NOISE_BIT = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              we,
  input  logic [2:0]        addr,
  input  logic [7:0]        wdata,
  input  logic              sync_in,
  output logic [ACC_W-1:0]  acc,
  output logic [LFSR_W-1:0] lfsr,
  output logic              msb_rise,
  output logic [11:0]       pw,
  output logic              gate,
  output logic              sync_en,
  output logic              ring,
  output logic              test,
  output logic              triangle,
  output logic              saw,
  output logic              pulse,
  output logic              noise,
  output logic [7:0]        attack_decay,
  output logic [7:0]        sustain_release
);

  logic [7:0]       freq_lo;
  logic [7:0]       freq_hi;
  logic [7:0]       pw_lo;
  logic [3:0]       pw_hi;
  sid_ctrl_t        ctrl;
  logic [7:0]       ad_reg;
  logic [7:0]       sr_reg;

  logic [15:0]      freq;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             msb_rise_next;
  logic             lfsr_shift;
  logic             lfsr_load;

  // Register bank: writes land on the edge; address 7 is a no-op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_lo <= 8'h00;
      freq_hi <= 8'h00;
      pw_lo   <= 8'h00;
      pw_hi   <= 4'h0;
      ctrl    <= '0;
      ad_reg  <= 8'h00;
      sr_reg  <= 8'h00;
    end else if (we) begin
      case (addr)
        SID_FREQ_LO: freq_lo <= wdata;
        SID_FREQ_HI: freq_hi <= wdata;
        SID_PW_LO:   pw_lo   <= wdata;
        SID_PW_HI:   pw_hi   <= wdata[3:0];
        SID_CONTROL: ctrl    <= sid_ctrl_t'(wdata);
        SID_AD:      ad_reg  <= wdata;
        SID_SR:      sr_reg  <= wdata;
        default: ;
      endcase
    end
  end

  // Next accumulator value from the current (pre-write) freq and control
  always_comb begin
    freq          = {freq_hi, freq_lo};
    acc_sum       = acc + {{(ACC_W-16){1'b0}}, freq};
    acc_next      = acc_sum;
    if (ctrl.test) begin
      acc_next = '0;
    end else if (ctrl.sync_en && sync_in) begin
      acc_next = '0;
    end
    // A cleared accumulator has MSB 0, so clears never report a rise
    msb_rise_next = ~acc[ACC_W-1] & acc_next[ACC_W-1];
    lfsr_shift    = tick & ~ctrl.test & ~acc[NOISE_BIT] & acc_next[NOISE_BIT];
  end

`ifdef SID_TEST_LFSR_RESET_EN
  // Test bit reseeds the noise generator on every tick
  always_comb begin
    lfsr_load = tick & ctrl.test;
  end
`else
  // Test bit only freezes the noise generator
  always_comb begin
    lfsr_load = 1'b0;
  end
`endif

  // Accumulator and MSB-rise flag advance only on tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      msb_rise <= 1'b0;
    end else if (tick) begin
      acc      <= acc_next;
      msb_rise <= msb_rise_next;
    end
  end

  sid_noise_lfsr #(
    .LFSR_W    (LFSR_W),
    .LFSR_SEED (LFSR_SEED)
  ) u_noise (
    .clk   (clk),
    .rst_n (rst_n),
    .shift (lfsr_shift),
    .load  (lfsr_load),
    .lfsr  (lfsr)
  );

  // Register-bank outputs toward the waveform and envelope generators
  always_comb begin
    pw              = {pw_hi, pw_lo};
    gate            = ctrl.gate;
    sync_en         = ctrl.sync_en;
    ring            = ctrl.ring;
    test            = ctrl.test;
    triangle        = ctrl.triangle;
    saw             = ctrl.saw;
    pulse           = ctrl.pulse;
    noise           = ctrl.noise;
    attack_decay    = ad_reg;
    sustain_release = sr_reg;
  end

endmodule

// File: tb/tb_sid_voice_osc.sv
// Directed self-checking bench for sid_voice_osc.
module tb_sid_voice_osc;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        we;
  logic [2:0]  addr;
  logic [7:0]  wdata;
  logic        sync_in;
  logic [23:0] acc;
  logic [22:0] lfsr;
  logic        msb_rise;
  logic [11:0] pw;
  logic        gate, sync_en, ring, test, triangle, saw, pulse, noise;
  logic [7:0]  attack_decay;
  logic [7:0]  sustain_release;
  logic [7:0]  ctrl_vec;

  int checks;
  int failures;

  sid_voice_osc dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tick            (tick),
    .we              (we),
    .addr            (addr),
    .wdata           (wdata),
    .sync_in         (sync_in),
    .acc             (acc),
    .lfsr            (lfsr),
    .msb_rise        (msb_rise),
    .pw              (pw),
    .gate            (gate),
    .sync_en         (sync_en),
    .ring            (ring),
    .test            (test),
    .triangle        (triangle),
    .saw             (saw),
    .pulse           (pulse),
    .noise           (noise),
    .attack_decay    (attack_decay),
    .sustain_release (sustain_release)
  );

  assign ctrl_vec = {noise, pulse, saw, triangle, test, ring, sync_en, gate};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // One tick followed by one idle clk; sampled after the idle edge
  task automatic tk();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (acc !== 24'h0) begin failures++; $display("FAIL reset_acc actual=%h required=%h", acc, 24'h0); end
    checks++;
    if (lfsr !== 23'h7FFFF8) begin failures++; $display("FAIL reset_lfsr actual=%h required=%h", lfsr, 23'h7FFFF8); end
    checks++;
    if (pw !== 12'h0) begin failures++; $display("FAIL reset_pw actual=%h required=%h", pw, 12'h0); end
    checks++;
    if (ctrl_vec !== 8'h00) begin failures++; $display("FAIL reset_ctrl actual=%h required=%h", ctrl_vec, 8'h00); end
    checks++;
    if (msb_rise !== 1'b0) begin failures++; $display("FAIL reset_msb actual=%b required=0", msb_rise); end
    checks++;
    if ({attack_decay, sustain_release} !== 16'h0) begin
      failures++; $display("FAIL reset_adsr actual=%h required=0000", {attack_decay, sustain_release});
    end
  endtask

  task automatic test_regs();
    do_reset();
    wr(3'd2, 8'hAB);
    wr(3'd3, 8'hFC);
    wr(3'd5, 8'h5A);
    wr(3'd6, 8'hC3);
    wr(3'd4, 8'hF1);
    checks++;
    if (pw !== 12'hCAB) begin failures++; $display("FAIL regs_pw actual=%h required=%h", pw, 12'hCAB); end
    checks++;
    if (attack_decay !== 8'h5A) begin failures++; $display("FAIL regs_ad actual=%h required=%h", attack_decay, 8'h5A); end
    checks++;
    if (sustain_release !== 8'hC3) begin failures++; $display("FAIL regs_sr actual=%h required=%h", sustain_release, 8'hC3); end
    checks++;
    if (ctrl_vec !== 8'hF1) begin failures++; $display("FAIL regs_ctrl actual=%h required=%h", ctrl_vec, 8'hF1); end
    wr(3'd7, 8'h00);
    checks++;
    if ({pw, attack_decay, sustain_release, ctrl_vec} !== {12'hCAB, 8'h5A, 8'hC3, 8'hF1}) begin
      failures++; $display("FAIL regs_addr7 actual=%h required=%h",
        {pw, attack_decay, sustain_release, ctrl_vec}, {12'hCAB, 8'h5A, 8'hC3, 8'hF1});
    end
  endtask

  task automatic test_freq();
    logic [23:0] exp_acc;
    do_reset();
    wr(3'd1, 8'h10);
    wr(3'd0, 8'h00);
    checks++;
    if (acc !== 24'h0) begin failures++; $display("FAIL freq_no_tick actual=%h required=000000", acc); end
    for (int i = 1; i <= 16; i++) begin
      tk();
      exp_acc = 24'(i) * 24'h001000;
      checks++;
      if (acc !== exp_acc) begin failures++; $display("FAIL freq_acc tick=%0d actual=%h required=%h", i, acc, exp_acc); end
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (acc !== 24'h010000) begin failures++; $display("FAIL freq_hold actual=%h required=%h", acc, 24'h010000); end
  endtask

  task automatic test_wrap();
    logic [23:0] exp_acc;
    logic        exp_msb;
    do_reset();
    wr(3'd1, 8'h80);
    for (int i = 1; i <= 512; i++) begin
      tk();
      exp_acc = 24'(i * 32'h8000);
      exp_msb = (i == 256);
      checks++;
      if (acc !== exp_acc) begin failures++; $display("FAIL wrap_acc tick=%0d actual=%h required=%h", i, acc, exp_acc); end
      checks++;
      if (msb_rise !== exp_msb) begin failures++; $display("FAIL wrap_msb tick=%0d actual=%b required=%b", i, msb_rise, exp_msb); end
      if (i == 15) begin
        checks++;
        if (lfsr !== 23'h7FFFF8) begin failures++; $display("FAIL lfsr_pre actual=%h required=%h", lfsr, 23'h7FFFF8); end
      end
      if (i == 16) begin
        checks++;
        if (lfsr !== 23'h7FFFF0) begin failures++; $display("FAIL lfsr_first actual=%h required=%h", lfsr, 23'h7FFFF0); end
      end
    end
  endtask

  task automatic test_test_bit();
    logic [22:0] exp_lfsr;
`ifdef SID_TEST_LFSR_RESET_EN
    exp_lfsr = 23'h7FFFF8;
`else
    exp_lfsr = 23'h7FFFF0;
`endif
    do_reset();
    wr(3'd1, 8'h80);
    repeat (20) tk();
    checks++;
    if ({acc, lfsr} !== {24'h0A0000, 23'h7FFFF0}) begin
      failures++; $display("FAIL testbit_pre actual=%h/%h required=0a0000/7ffff0", acc, lfsr);
    end
    wr(3'd4, 8'h08);
    checks++;
    if (acc !== 24'h0A0000) begin failures++; $display("FAIL testbit_write_only actual=%h required=0a0000", acc); end
    tk();
    checks++;
    if (acc !== 24'h0) begin failures++; $display("FAIL testbit_clear actual=%h required=000000", acc); end
    checks++;
    if (lfsr !== exp_lfsr) begin failures++; $display("FAIL testbit_lfsr actual=%h required=%h", lfsr, exp_lfsr); end
    checks++;
    if (msb_rise !== 1'b0) begin failures++; $display("FAIL testbit_msb actual=%b required=0", msb_rise); end
    tk();
    checks++;
    if (acc !== 24'h0) begin failures++; $display("FAIL testbit_stay actual=%h required=000000", acc); end
    wr(3'd4, 8'h00);
    tk();
    checks++;
    if (acc !== 24'h008000) begin failures++; $display("FAIL testbit_resume actual=%h required=008000", acc); end
  endtask

  task automatic test_sync();
    do_reset();
    wr(3'd1, 8'h12);
    wr(3'd0, 8'h34);
    repeat (256) tk();
    checks++;
    if (acc !== 24'h123400) begin failures++; $display("FAIL sync_pre actual=%h required=123400", acc); end
    wr(3'd4, 8'h02);
    sync_in = 1'b1;
    tk();
    sync_in = 1'b0;
    checks++;
    if (acc !== 24'h0) begin failures++; $display("FAIL sync_clear actual=%h required=000000", acc); end
    checks++;
    if (msb_rise !== 1'b0) begin failures++; $display("FAIL sync_msb actual=%b required=0", msb_rise); end
    do_reset();
    wr(3'd1, 8'h12);
    wr(3'd0, 8'h34);
    repeat (256) tk();
    sync_in = 1'b1;
    tk();
    sync_in = 1'b0;
    checks++;
    if (acc !== 24'h124634) begin failures++; $display("FAIL sync_disabled actual=%h required=124634", acc); end
  endtask

  task automatic test_collision();
    do_reset();
    wr(3'd0, 8'h01);
    tk();
    checks++;
    if (acc !== 24'h000001) begin failures++; $display("FAIL coll_first actual=%h required=000001", acc); end
    @(negedge clk);
    we = 1'b1; addr = 3'd0; wdata = 8'h05; tick = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0; tick = 1'b0;
    checks++;
    if (acc !== 24'h000002) begin failures++; $display("FAIL coll_old_freq actual=%h required=000002", acc); end
    tk();
    checks++;
    if (acc !== 24'h000007) begin failures++; $display("FAIL coll_new_freq actual=%h required=000007", acc); end
    wr(3'd7, 8'hFF);
    tk();
    checks++;
    if (acc !== 24'h00000C) begin failures++; $display("FAIL coll_addr7_freq actual=%h required=00000c", acc); end
    checks++;
    if ({pw, ctrl_vec, attack_decay, sustain_release} !== 36'h0) begin
      failures++; $display("FAIL coll_addr7_regs actual=%h required=0", {pw, ctrl_vec, attack_decay, sustain_release});
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    wr(3'd1, 8'h80);
    repeat (17) tk();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({acc, lfsr, msb_rise} !== {24'h0, 23'h7FFFF8, 1'b0}) begin
      failures++; $display("FAIL midreset_async actual=%h/%h/%b required=000000/7ffff8/0", acc, lfsr, msb_rise);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr(3'd0, 8'h03);
    tk();
    checks++;
    if (acc !== 24'h000003) begin failures++; $display("FAIL midreset_restart actual=%h required=000003", acc); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    tick     = 1'b0;
    we       = 1'b0;
    addr     = 3'd0;
    wdata    = 8'h00;
    sync_in  = 1'b0;
    test_reset();
    test_regs();
    test_freq();
    test_wrap();
    test_test_bit();
    test_sync();
    test_collision();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
